// File: rtl/scrub_sequencer.sv
// -----------------------------------------------------------------------------
// scrub_sequencer
//
// Feeds the registered clear/select output stage. Incoming words are held in
// a 2-entry FIFO and handed on one at a time, each as a one-cycle out_valid
// pulse. A secret_req opens a timed scrub window. During that window the
// clear-select (scrub) is held high so the downstream stage outputs 0, and no
// buffered data is released. The window ends with a single FLUSH cycle that
// throws away every word accepted before the window closed.
//
// Taint view: in_data is the source, out_data is the sink, and scrub is the
// sanitized control.
//
// Optional feature (compile-time macro SCRUB_SEQUENCER_KEEP_EN):
//   undefined : FLUSH clears the FIFO (default build).
//   defined   : FLUSH keeps the FIFO contents. Held words then drain in order
//               after the window closes.
//
// Parameters
//   WIDTH        data word width
//   SCRUB_CYCLES length of the scrub window in SCRUB cycles (0 acts as 1)
//   CNT_W        scrub counter width; SCRUB_CYCLES must not exceed 2**CNT_W
//
// Ports
//   clk        clock; all state changes on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word this cycle
//   in_data    upstream word
//   secret_req single-cycle request to open (or extend) a scrub window
//   out_valid  out_data holds a fresh word this cycle (registered)
//   out_data   data to the downstream stage (registered)
//   scrub      clear-select to the downstream stage (registered)
//   busy       sequencer is not idle (registered)
// -----------------------------------------------------------------------------
module scrub_sequencer #(
   parameter int WIDTH        = 1,
   parameter int SCRUB_CYCLES = 4,
   parameter int CNT_W        = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             secret_req,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             scrub,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_SCRUB = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // A zero-length window is treated as a one-cycle window.
   localparam int              LOAD_I   = (SCRUB_CYCLES < 1) ? 0 : SCRUB_CYCLES - 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // FIFO storage and bookkeeping
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             full;
   logic             empty;
   logic [WIDTH-1:0] head;

   // ready_en stays low in reset, so in_ready is 0 until the first clock edge
   // after release. It is not gated directly by rst_n.
   logic             ready_en;

   logic             push;
   logic             pop;
   logic             fifo_clear;

   logic             out_valid_d;
   logic [WIDTH-1:0] out_data_d;
   logic             scrub_d;
   logic             busy_d;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign head  = mem[rd_ptr];

   // Derived from registered state only: there is no combinational path
   // from in_valid or secret_req.
   assign in_ready = ready_en && !full && (state != ST_FLUSH);
   assign push     = in_valid && in_ready;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (secret_req)
               state_next = ST_SCRUB;
            else if (push)
               state_next = ST_PASS;
         end
         ST_PASS: begin
            // secret_req wins over the pending pop.
            if (secret_req)
               state_next = ST_SCRUB;
            else if (empty && !push)
               state_next = ST_IDLE;
         end
         ST_SCRUB: begin
            if (secret_req)
               state_next = ST_SCRUB;
            else if (cnt == '0)
               state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (secret_req)
               state_next = ST_SCRUB;
            else begin
`ifdef SCRUB_SEQUENCER_KEEP_EN
               state_next = empty ? ST_IDLE : ST_PASS;
`else
               state_next = ST_IDLE;
`endif
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / datapath control logic (values registered below)
   // ---------------------------------------------------------------------------
   always_comb begin
      pop         = (state == ST_PASS) && !empty && !secret_req;
`ifdef SCRUB_SEQUENCER_KEEP_EN
      fifo_clear  = 1'b0;
`else
      fifo_clear  = (state == ST_FLUSH);
`endif

      // The counter is reloaded on every entry into SCRUB and on every
      // secret_req seen while in SCRUB, which extends the window.
      cnt_next = cnt;
      if ((state_next == ST_SCRUB) && ((state != ST_SCRUB) || secret_req))
         cnt_next = CNT_LOAD;
      else if ((state == ST_SCRUB) && (cnt != '0))
         cnt_next = cnt - 1'b1;

      // Registered outputs follow the next state. This way scrub rises in
      // the first SCRUB cycle and stays high through FLUSH, with no gap
      // when FLUSH goes straight back to SCRUB.
      scrub_d     = (state_next == ST_SCRUB) || (state_next == ST_FLUSH);
      busy_d      = (state_next != ST_IDLE);
      out_valid_d = pop;
      out_data_d  = pop ? head : '0;
   end

   // ---------------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (fifo_clear) begin
            // in_ready is low in FLUSH, so no push can collide with the clear.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
         end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // FIFO storage: data only, so it has no reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         scrub     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         scrub     <= scrub_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_scrub_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scrub_sequencer
//
// Directed testbench for scrub_sequencer with its default parameters
// (WIDTH=1, SCRUB_CYCLES=4). The expected values are worked out by hand from
// the sequencing rules. Define SCRUB_SEQUENCER_KEEP_EN for both the RTL and
// this bench to exercise the keep-on-flush variant.
// -----------------------------------------------------------------------------
module tb_scrub_sequencer;

`ifdef SCRUB_SEQUENCER_KEEP_EN
   localparam bit KEEP = 1'b1;
`else
   localparam bit KEEP = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [0:0] in_data;
   logic       secret_req;
   logic       out_valid;
   logic [0:0] out_data;
   logic       scrub;
   logic       busy;

   int checks;
   int failures;
   int n;
   int bad;

   scrub_sequencer #(
      .WIDTH       (1),
      .SCRUB_CYCLES(4),
      .CNT_W       (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .secret_req(secret_req),
      .out_valid (out_valid),
      .out_data  (out_data),
      .scrub     (scrub),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count consecutive scrub-high cycles from now on. secret_req is pulsed
   // on the reext-th cycle (0 = never). The count is bounded, so a stuck
   // scrub line shows up as a wrong count instead of a hang.
   task automatic run_window(input int reext, output int cyc, output int ov);
      cyc = 0;
      ov  = 0;
      while (scrub === 1'b1 && cyc < 40) begin
         cyc++;
         if (out_valid !== 1'b0) ov++;
         secret_req = (reext != 0) && (cyc == reext);
         step();
      end
      secret_req = 1'b0;
   endtask

   // Check what happens after a scrub window closes with words w0,w1 buffered:
   // they are either dropped, or drained in order in the keep variant.
   task automatic check_drain(input string tag, input logic w0, input logic w1);
      check({tag, "_end_valid"}, out_valid, 0);
      check({tag, "_end_busy"}, busy, KEEP);
      step();
      check({tag, "_d0_valid"}, out_valid, KEEP);
      check({tag, "_d0_data"}, out_data, KEEP ? w0 : 1'b0);
      step();
      check({tag, "_d1_valid"}, out_valid, KEEP);
      check({tag, "_d1_data"}, out_data, KEEP ? w1 : 1'b0);
      step();
      check({tag, "_d2_valid"}, out_valid, 0);
      check({tag, "_d2_busy"}, busy, 0);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 1'b0;
      secret_req = 1'b0;

      // Reset values
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_scrub", scrub, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #7 rst_n = 1'b1;
      #1;
      check("rel_in_ready_pre", in_ready, 0);
      step();
      check("rel_in_ready_post", in_ready, 1);

      // Pass-through of 1,0,1
      in_valid = 1'b1;
      in_data  = 1'b1;
      step();
      check("p_v0", out_valid, 0);
      check("p_busy", busy, 1);
      in_data = 1'b0;
      step();
      check("p_v1", out_valid, 1);
      check("p_d1", out_data, 1);
      check("p_s1", scrub, 0);
      in_data = 1'b1;
      step();
      check("p_v2", out_valid, 1);
      check("p_d2", out_data, 0);
      check("p_s2", scrub, 0);
      in_valid = 1'b0;
      step();
      check("p_v3", out_valid, 1);
      check("p_d3", out_data, 1);
      check("p_s3", scrub, 0);
      step();
      check("p_v4", out_valid, 0);
      check("p_busy_end", busy, 0);
      check("p_s4", scrub, 0);

      // Scrub from an empty IDLE, filling the FIFO during the window
      secret_req = 1'b1;
      step();
      secret_req = 1'b0;
      check("w_s1", scrub, 1);
      check("w_busy", busy, 1);
      check("w_v1", out_valid, 0);
      check("w_rdy1", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 1'b1;
      step();
      check("w_s2", scrub, 1);
      check("w_rdy2", in_ready, 1);
      in_data = 1'b0;
      step();
      check("w_s3", scrub, 1);
      check("w_rdy_full3", in_ready, 0);
      check("w_v3", out_valid, 0);
      in_data = 1'b1;
      step();
      check("w_s4", scrub, 1);
      check("w_rdy_full4", in_ready, 0);
      step();
      check("w_s5_flush", scrub, 1);
      check("w_rdy_flush", in_ready, 0);
      check("w_v5", out_valid, 0);
      in_valid = 1'b0;
      step();
      check("w_s6_off", scrub, 0);
      check_drain("w", 1'b1, 1'b0);

      // Window extended by a re-request on the 3rd SCRUB cycle: 3+4+1
      secret_req = 1'b1;
      step();
      secret_req = 1'b0;
      run_window(3, n, bad);
      check("ext_len", n, 8);
      check("ext_no_valid", bad, 0);

      // Word accepted in the same cycle as secret_req, FIFO non-empty
      in_valid = 1'b1;
      in_data  = 1'b1;
      step();
      check("ne_v0", out_valid, 0);
      in_data    = 1'b0;
      secret_req = 1'b1;
      step();
      in_valid   = 1'b0;
      secret_req = 1'b0;
      run_window(0, n, bad);
      check("ne_len", n, 5);
      check("ne_no_valid", bad, 0);
      check_drain("ne", 1'b1, 1'b0);

      // secret_req during FLUSH re-enters SCRUB with no gap: 5+5
      secret_req = 1'b1;
      step();
      secret_req = 1'b0;
      run_window(5, n, bad);
      check("fl_len", n, 10);
      check("fl_no_valid", bad, 0);
      check("fl_busy", busy, 0);

      // Asynchronous reset in the middle of a window
      in_valid   = 1'b1;
      in_data    = 1'b1;
      secret_req = 1'b1;
      step();
      in_valid   = 1'b0;
      secret_req = 1'b0;
      check("ar_s1", scrub, 1);
      step();
      check("ar_s2", scrub, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_scrub", scrub, 0);
      check("ar_busy", busy, 0);
      check("ar_valid", out_valid, 0);
      check("ar_data", out_data, 0);
      check("ar_rdy", in_ready, 0);
      #3 rst_n = 1'b1;
      step();
      check("ar_rdy_rel", in_ready, 1);
      check("ar_busy_rel", busy, 0);
      in_valid = 1'b1;
      in_data  = 1'b0;
      step();
      in_valid = 1'b0;
      check("ar_v0", out_valid, 0);
      step();
      check("ar_v1", out_valid, 1);
      check("ar_d1", out_data, 0);
      step();
      check("ar_v2", out_valid, 0);
      check("ar_busy_end", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
